div_32_seq: RTL and testbench

Multi-cycle 32-bit integer divider for the CPU datapath. Division is the inverse of the multiply path, and this block performs it by repeated trial subtraction: one restoring step per clock. The execute stage starts it with a single-cycle `start` pulse and stalls on `busy`. The quotient and remainder are collected on the `done` pulse.

---
 rtl/div_32_seq.sv | 138 +++++++++++++
 tb/tb_div_32_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_32_seq.sv
// rtl/div_32_seq.sv - 32-bit sequential restoring divider, one quotient bit per clock (optional signed mode: DIV_SIGNED_EN)
module div_32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        Sign,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        busy,
    output logic        done,
    output logic        DivZero
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] part;      // partial remainder (never exceeds the divisor, so 32 bits hold it)
    logic [31:0] quo;       // dividend shifting out, quotient shifting in
    logic [31:0] dvs;       // divisor magnitude
    logic [31:0] x_raw;     // original dividend, returned as remainder on divide by zero

    logic [32:0] part_sh;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] x_mag;
    logic [31:0] y_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic x_neg;
    logic y_neg;

    // Operand magnitudes when signed mode is requested
    always_comb begin
        x_neg = Sign & X[31];
        y_neg = Sign & Y[31];
        x_mag = x_neg ? (~X + 32'd1) : X;
        y_mag = y_neg ? (~Y + 32'd1) : Y;
    end

    // Sign fixups applied to the unsigned result
    always_comb begin
        q_fix = q_neg ? (~quo + 32'd1) : quo;
        r_fix = r_neg ? (~part + 32'd1) : part;
    end
`else
    logic unused_sign;
    assign unused_sign = Sign;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        x_mag = X;
        y_mag = Y;
        q_fix = quo;
        r_fix = part;
    end
`endif

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    // part < dvs keeps part_sh < 2*dvs, so bit 32 of the 33-bit difference is the borrow.
    always_comb begin
        part_sh = {part, quo[31]};
        trial   = part_sh - {1'b0, dvs};
        q_bit   = ~trial[32];
    end

    // Control FSM with registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            part    <= 32'd0;
            quo     <= 32'd0;
            dvs     <= 32'd0;
            x_raw   <= 32'd0;
            Q       <= 32'd0;
            R       <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_raw <= X;
                        quo   <= x_mag;
                        dvs   <= y_mag;
                        part  <= 32'd0;
                        cnt   <= 5'd0;
                        busy  <= 1'b1;
                        state <= CALC;
`ifdef DIV_SIGNED_EN
                        q_neg <= x_neg ^ y_neg;
                        r_neg <= x_neg;
`endif
                    end
                end
                CALC: begin
                    part <= q_bit ? trial[31:0] : part_sh[31:0];
                    quo  <= {quo[30:0], q_bit};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (dvs == 32'd0) begin
                        Q       <= 32'hFFFF_FFFF;
                        R       <= x_raw;
                        DivZero <= 1'b1;
                    end else begin
                        Q       <= q_fix;
                        R       <= r_fix;
                        DivZero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_32_seq.sv
// tb/tb_div_32_seq.sv - scoreboard testbench for div_32_seq against an arithmetic reference model
module tb_div_32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        Sign;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        done;
    logic        DivZero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    div_32_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Sign    (Sign),
        .X       (X),
        .Y       (Y),
        .Q       (Q),
        .R       (R),
        .busy    (busy),
        .done    (done),
        .DivZero (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t e;
        logic signed_mode;
`ifdef DIV_SIGNED_EN
        signed_mode = s;
`else
        signed_mode = 1'b0 & s;
`endif
        e.dz = 1'b0;
        if (y == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = x;
            e.dz = 1'b1;
        end else if (signed_mode) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = $signed(x) / $signed(y);
                e.r = $signed(x) % $signed(y);
            end
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual Q=%h R=%h DivZero=%b required no done", Q, R, DivZero);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Q !== e.q || R !== e.r || DivZero !== e.dz) begin
                    errors++;
                    $display("FAIL result actual Q=%h R=%h DZ=%b required Q=%h R=%h DZ=%b",
                             Q, R, DivZero, e.q, e.r, e.dz);
                end
            end
        end
    end

    // Issue one operation. intr: edge at which a stray start is pulsed; abort: edge at which rst hits.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int intr, input int abort);
        int   n;
        int   bc;
        exp_t e;
        X = x; Y = y; Sign = s; start = 1'b1;
        e = model(x, y, s);
        if (abort == 0) sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        X = $urandom; Y = $urandom; Sign = $urandom_range(0, 1);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("q_r_hold", {Q, R}, {prev_q, prev_r});
        n  = 0;
        bc = 1;
        while (!done && n < 40) begin
            if (n + 1 == intr) begin
                X = 32'd9; Y = 32'd3; start = 1'b1;
            end
            if (n + 1 == abort) rst = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (n == abort) begin
                chk("abort_state", {Q, R}, 64'd0);
                chk("abort_flags", {61'd0, busy, done, DivZero}, 64'd0);
                rst    = 1'b0;
                prev_q = 32'd0;
                prev_r = 32'd0;
                repeat (40) @(posedge clk);
                #1;
                chk("abort_quiet", {62'd0, busy, done}, 64'd0);
                return;
            end
            if (busy) bc++;
        end
        chk("latency", n, 33);
        chk("busy_cycles", bc, 33);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        prev_q = e.q;
        prev_r = e.r;
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        rst = 1'b1; start = 1'b0; Sign = 1'b0; X = 32'd0; Y = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_qr", {Q, R}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, DivZero}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(32'd100, 32'd7, 1'b0, 0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
        do_op(32'd5, 32'd0, 1'b0, 0, 0);
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        do_op(32'd50, 32'd5, 1'b0, 10, 0);
        do_op(32'd1234, 32'd11, 1'b0, 0, 15);
        do_op(32'd9, 32'd4, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       rx = 32'h8000_0000;
                1:       rx = $urandom_range(0, 255);
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = $urandom_range(1, 15);
                3:       ry = rx;
                default: ry = $urandom;
            endcase
            do_op(rx, ry, 1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
